trng_conditioner: RTL
=====================

TRNG_CONDITIONER -- requirements
Module: trng_conditioner

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 8: random word width (2..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: output FIFO depth in words (power of 2, >=2).
REQ-003 SHALL have parameter REP_LIMIT, default 32: repetition-count health-test cutoff (2..255).
REQ-004 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port raw_bit  input  1  raw entropy sample from the oscillator source.
REQ-007 SHALL have port raw_valid  input  1  raw_bit is sampled on an edge where raw_valid=1.
REQ-008 SHALL have port debias_en  input  1  1 = von Neumann debiasing; 0 = pass-through.
REQ-009 SHALL have port clear_fail  input  1  clears health_fail and restarts collection.
REQ-010 SHALL have port rand_out  output  OUT_WIDTH  FIFO head word.
REQ-011 SHALL have port rand_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port rand_ready  input  1  consumer accepts rand_out.
REQ-013 SHALL have port fifo_count  output  clog2(FIFO_DEPTH+1)  words held.
REQ-014 SHALL have port health_fail  output  1  sticky repetition-test failure.
REQ-015 SHALL have port overrun  output  1  sticky: a completed word was dropped.

Function
REQ-016 Repetition test SHALL run on every raw sample regardless of debias_en: run counter = 1 on the first sample after reset/clear, +1 when raw_bit equals the previous sample, else 1.
REQ-017 When the run counter would reach REP_LIMIT, health_fail SHALL set at that edge; the triggering sample is discarded, the partial word and held debias bit are cleared.
REQ-018 While health_fail=1, no sample SHALL be accepted into debias/shift logic; FIFO contents stay readable.
REQ-019 clear_fail=1 SHALL clear health_fail, run counter, partial word and debias state; a sample on the same edge is discarded.
REQ-020 debias_en=0: every valid sample SHALL be an accepted bit.
REQ-021 debias_en=1: two-state FSM EMPTY/HELD; EMPTY+sample -> HELD (store bit); HELD+sample -> EMPTY, accept held bit if it differs from new sample, else discard both.
REQ-022 A debias_en change SHALL force FSM to EMPTY and discard any held bit on that edge; the partial word is kept.
REQ-023 Accepted bits SHALL shift in MSB-first: word <= {word[OUT_WIDTH-2:0], bit}; bit counter counts 0..OUT_WIDTH-1.
REQ-024 On the edge accepting bit OUT_WIDTH, the completed word SHALL be pushed into the FIFO at that edge and the bit counter SHALL return to 0; rand_valid rises the following cycle (latency 1 from last bit).
REQ-025 rand_valid SHALL equal (fifo_count != 0); pop on edge where rand_valid & rand_ready.
REQ-026 Push while full SHALL be accepted only if a pop occurs on the same edge; otherwise the word is dropped and overrun sets.
REQ-027 Push and pop on the same edge with FIFO non-empty SHALL leave fifo_count unchanged; FIFO order strictly first-in first-out; pointers wrap modulo FIFO_DEPTH.
REQ-028 rand_ready with FIFO empty SHALL have no effect; overrun clears only on reset.

Reset
REQ-029 reset=1 SHALL, at the clock edge, clear FIFO (fifo_count=0, rand_valid=0), rand_out=0, health_fail=0, overrun=0, run counter, bit counter, partial word and FSM (EMPTY); reset dominates all other inputs, including mid-word or mid-pair.

Verification
REQ-030 Defaults, debias_en=0, samples 1,0,1,1,0,0,1,0 -> one cycle after the 8th, rand_valid=1, rand_out=8'hB2, fifo_count=1.
REQ-031 debias_en=1, pairs (1,0)x4,(1,1),(0,1)x4,(0,0) -> rand_out=8'hF0; pairs (1,1)/(0,0) produce no bit.
REQ-032 rand_ready=0, 40 alternating samples (5 words of 8'hAA) -> fifo_count=4, overrun=1, rand_out=8'hAA; then rand_ready=1 for 4 cycles -> fifo_count=0, rand_valid=0.
REQ-033 debias_en=0, 32 consecutive 1s -> 3 words 8'hFF in FIFO, health_fail=1 after 32nd sample, later samples ignored; clear_fail pulse then 8 samples of 8'h5A pattern -> 4th word 8'h5A.
REQ-034 Full FIFO, rand_ready=1 on the edge the 5th word completes -> fifo_count stays 4, overrun stays 0.
REQ-035 reset asserted after 5 of 8 bits with 2 words queued -> next cycle fifo_count=0, rand_valid=0, rand_out=0; 8 new samples yield exactly one fresh word.

Source files
------------

// File: rtl/trng_conditioner.sv
// Raw entropy conditioner: repetition-count health test, optional von Neumann
// debiasing, MSB-first word assembly and a small first-word-fall-through FIFO.
module trng_conditioner #(
    parameter int OUT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int REP_LIMIT  = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               raw_bit,
    input  logic                               raw_valid,
    input  logic                               debias_en,
    input  logic                               clear_fail,
    output logic [OUT_WIDTH-1:0]               rand_out,
    output logic                               rand_valid,
    input  logic                               rand_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               health_fail,
    output logic                               overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {EMPTY, HELD} db_state_t;

    db_state_t              db_state_reg, db_state_next;
    logic                   held_reg, held_next;
    logic                   debias_prev_reg;
    logic                   prev_bit_reg;
    logic [7:0]             run_reg, run_new;
    logic [OUT_WIDTH-1:0]   word_reg, shifted;
    logic [5:0]             bit_cnt_reg;
    logic [OUT_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]          count_reg, count_next;
    logic [OUT_WIDTH-1:0]   head_reg;
    logic                   valid_reg, health_fail_reg, overrun_reg;

    logic live, trip, mode_change, accept, acc_bit, word_done;
    logic pop, full, push, drop;

    always_comb begin
        run_new       = (run_reg != 8'd0 && raw_bit == prev_bit_reg) ? run_reg + 8'd1 : 8'd1;
        live          = raw_valid && !health_fail_reg && !clear_fail;
        trip          = live && (run_new == 8'(REP_LIMIT));
        mode_change   = (debias_en != debias_prev_reg);
        accept        = 1'b0;
        acc_bit       = raw_bit;
        db_state_next = db_state_reg;
        held_next     = held_reg;
        if (mode_change)
            db_state_next = EMPTY;
        if (live && !trip) begin
            if (!debias_en) begin
                accept = 1'b1;
            end else if (!mode_change) begin
                // A sample arriving on a mode-switch edge is dropped so pairs never straddle modes.
                if (db_state_reg == EMPTY) begin
                    db_state_next = HELD;
                    held_next     = raw_bit;
                end else begin
                    db_state_next = EMPTY;
                    if (held_reg != raw_bit) begin
                        accept  = 1'b1;
                        acc_bit = held_reg;
                    end
                end
            end
        end
        if (trip || clear_fail)
            db_state_next = EMPTY;

        word_done = accept && (bit_cnt_reg == 6'(OUT_WIDTH - 1));
        shifted   = {word_reg[OUT_WIDTH-2:0], acc_bit};

        pop         = valid_reg && rand_ready;
        full        = (count_reg == CW'(FIFO_DEPTH));
        push        = word_done && (!full || pop);
        drop        = word_done && full && !pop;
        rd_ptr_next = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
        count_next  = count_reg;
        if (push && !pop)
            count_next = count_reg + CW'(1);
        else if (pop && !push)
            count_next = count_reg - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= shifted;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            db_state_reg    <= EMPTY;
            held_reg        <= 1'b0;
            debias_prev_reg <= debias_en;
            prev_bit_reg    <= 1'b0;
            run_reg         <= 8'd0;
            word_reg        <= '0;
            bit_cnt_reg     <= 6'd0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            head_reg        <= '0;
            valid_reg       <= 1'b0;
            health_fail_reg <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            debias_prev_reg <= debias_en;
            db_state_reg    <= db_state_next;
            held_reg        <= held_next;
            if (clear_fail) begin
                health_fail_reg <= 1'b0;
                run_reg         <= 8'd0;
                word_reg        <= '0;
                bit_cnt_reg     <= 6'd0;
            end else if (live) begin
                prev_bit_reg <= raw_bit;
                if (trip) begin
                    health_fail_reg <= 1'b1;
                    word_reg        <= '0;
                    bit_cnt_reg     <= 6'd0;
                end else begin
                    run_reg <= run_new;
                    if (accept) begin
                        word_reg    <= shifted;
                        bit_cnt_reg <= word_done ? 6'd0 : bit_cnt_reg + 6'd1;
                    end
                end
            end

            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            valid_reg   <= (count_next != '0);
            overrun_reg <= overrun_reg | drop;
            // Head register is the registered RAM read at the next read pointer, with write bypass.
            if (count_next == '0)
                head_reg <= '0;
            else if (push && wr_ptr_reg == rd_ptr_next)
                head_reg <= shifted;
            else
                head_reg <= mem[rd_ptr_next];
        end
    end

    assign rand_out    = head_reg;
    assign rand_valid  = valid_reg;
    assign fifo_count  = count_reg;
    assign health_fail = health_fail_reg;
    assign overrun     = overrun_reg;

endmodule
